// File: rtl/sha256_byte_padder.sv
// sha256_byte_padder
//   Receives a byte stream (byte_rdy / byte_stop / data_in), packs the bytes
//   big-endian into 512-bit blocks, appends SHA-256 padding (0x80, zero fill,
//   64-bit message bit length) and hands each block to the compression stage
//   over a valid/ready handshake.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears all state
//   byte_rdy      data_in holds a message byte this cycle
//   byte_stop     level; message has ended, padding may begin
//   data_in       message byte
//   block_ready   compressor accepts block_data this cycle
//   block_valid   block_data holds a complete block
//   block_data    block, first byte in [511:504]
//   block_first   with block_valid: first block of the message
//   block_last    with block_valid: final, length-bearing block
//   overflow_err  sticky: byte arrived while the byte counter was saturated
//   drop_err      sticky: byte arrived while not absorbing
//   busy          high except when absorbing with an empty buffer, or done
//
// State      | meaning
// -----------+-----------------------------------------------------------
// ABSORB     | collecting message bytes into the buffer
// EMIT       | full data (or 0x80) block offered to the compressor
// PAD80      | writing the 0x80 terminator byte
// PADLEN     | writing the 64-bit bit length into slots 56..63
// EMITLAST   | final length-bearing block offered to the compressor
// DONE       | message finished, waiting for byte_stop to drop

module sha256_byte_padder #(
  parameter int CNT_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         byte_rdy,
  input  logic         byte_stop,
  input  logic [7:0]   data_in,
  input  logic         block_ready,
  output logic         block_valid,
  output logic [511:0] block_data,
  output logic         block_first,
  output logic         block_last,
  output logic         overflow_err,
  output logic         drop_err,
  output logic         busy
);

  typedef enum logic [2:0] {
    ABSORB   = 3'd0,
    EMIT     = 3'd1,
    PAD80    = 3'd2,
    PADLEN   = 3'd3,
    EMITLAST = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t       state, state_nxt;
  logic [511:0] blk_buf;
  logic [6:0]   ptr;
  logic [CNT_W-1:0] cnt;
  logic         first_pend;
  logic         pad_pending;

  logic         cnt_full;
  logic         ptr_full;
  logic         accept;
  logic         drop;
  logic         ovf;
  logic         handshake;
  logic [6:0]   ptr_inc;
  logic [8:0]   bit_hi;
  logic [63:0]  bit_len;

  assign cnt_full  = &cnt;
  assign ptr_full  = (ptr == 7'd64);
  assign accept    = (state == ABSORB) && byte_rdy && !ptr_full && !cnt_full;
  assign drop      = byte_rdy && ((state != ABSORB) || ptr_full);
  assign ovf       = byte_rdy && (state == ABSORB) && !ptr_full && cnt_full;
  assign handshake = block_valid && block_ready;
  assign ptr_inc   = ptr + 7'd1;
  // MSB of byte slot ptr; slot 0 lives at [511:504]
  assign bit_hi    = 9'd511 - {ptr[5:0], 3'b000};
  assign bit_len   = 64'({cnt, 3'b000});

  assign block_valid = (state == EMIT) || (state == EMITLAST);
  assign block_data  = blk_buf;
  assign block_first = block_valid && first_pend;
  assign block_last  = (state == EMITLAST);
  assign busy        = !(((state == ABSORB) && (ptr == 7'd0)) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      ABSORB: begin
        // a full buffer must be emitted before any pending stop is honoured
        if (ptr_full || (accept && (ptr == 7'd63)))
          state_nxt = EMIT;
        else if (byte_stop)
          state_nxt = PAD80;
      end
      EMIT: begin
        if (handshake)
          state_nxt = pad_pending ? PADLEN : ABSORB;
      end
      PAD80: begin
        // no room for the length field after the 0x80 -> spill to a new block
        state_nxt = (ptr_inc <= 7'd56) ? PADLEN : EMIT;
      end
      PADLEN:   state_nxt = EMITLAST;
      EMITLAST: begin
        if (handshake)
          state_nxt = DONE;
      end
      DONE: begin
        if (!byte_stop)
          state_nxt = ABSORB;
      end
      default:  state_nxt = ABSORB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ABSORB;
      blk_buf      <= '0;
      ptr          <= '0;
      cnt          <= '0;
      first_pend   <= 1'b1;
      pad_pending  <= 1'b0;
      overflow_err <= 1'b0;
      drop_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (drop)
        drop_err <= 1'b1;
      if (ovf)
        overflow_err <= 1'b1;
      case (state)
        ABSORB: begin
          if (accept) begin
            blk_buf[bit_hi -: 8] <= data_in;
            ptr                  <= ptr_inc;
            cnt                  <= cnt + 1'b1;
          end
        end
        PAD80: begin
          blk_buf[bit_hi -: 8] <= 8'h80;
          ptr                  <= ptr_inc;
          pad_pending          <= (ptr_inc > 7'd56);
        end
        PADLEN: begin
          // zero fill is already in place: the buffer is cleared on every handshake
          blk_buf[63:0] <= bit_len;
          pad_pending   <= 1'b0;
        end
        EMIT, EMITLAST: begin
          if (handshake) begin
            blk_buf    <= '0;
            ptr        <= '0;
            first_pend <= 1'b0;
          end
        end
        DONE: begin
          if (!byte_stop) begin
            cnt        <= '0;
            first_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_byte_padder.sv
module tb_sha256_byte_padder;

  logic         clk = 1'b0;
  logic         rst_a, rst_b;
  logic         byte_rdy, byte_stop, block_ready;
  logic [7:0]   data_in;

  logic         bv_a, bf_a, bl_a, ovf_a, drp_a, busy_a;
  logic [511:0] bd_a;
  logic         bv_b, bf_b, bl_b, ovf_b, drp_b, busy_b;
  logic [511:0] bd_b;

  logic         sel_b = 1'b0;
  logic         mon_rst, mon_valid, mon_first, mon_last, mon_ovf, mon_drop, mon_busy;
  logic [511:0] mon_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  sha256_byte_padder dut_a (
    .clk(clk), .reset(rst_a), .byte_rdy(byte_rdy), .byte_stop(byte_stop),
    .data_in(data_in), .block_ready(block_ready), .block_valid(bv_a),
    .block_data(bd_a), .block_first(bf_a), .block_last(bl_a),
    .overflow_err(ovf_a), .drop_err(drp_a), .busy(busy_a)
  );

  sha256_byte_padder #(.CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .byte_rdy(byte_rdy), .byte_stop(byte_stop),
    .data_in(data_in), .block_ready(block_ready), .block_valid(bv_b),
    .block_data(bd_b), .block_first(bf_b), .block_last(bl_b),
    .overflow_err(ovf_b), .drop_err(drp_b), .busy(busy_b)
  );

  assign mon_rst   = sel_b ? rst_b : rst_a;
  assign mon_valid = sel_b ? bv_b  : bv_a;
  assign mon_data  = sel_b ? bd_b  : bd_a;
  assign mon_first = sel_b ? bf_b  : bf_a;
  assign mon_last  = sel_b ? bl_b  : bl_a;
  assign mon_ovf   = sel_b ? ovf_b : ovf_a;
  assign mon_drop  = sel_b ? drp_b : drp_a;
  assign mon_busy  = sel_b ? busy_b : busy_a;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every accepted block is compared against the queue head
  always @(negedge clk) begin
    if (!mon_rst && mon_valid && block_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got %0h expected none", mon_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("block_data", mon_data, mon_e.data);
        check("block_first", 512'(mon_first), 512'(mon_e.first));
        check("block_last", 512'(mon_last), 512'(mon_e.last));
      end
    end
  end

  // reference padding: message bytes seed, seed+1, ...
  task automatic push_msg(input int n, input logic [7:0] seed);
    logic [7:0]  m[$];
    logic [63:0] len;
    exp_t        e;
    int          nblk;
    for (int i = 0; i < n; i++) m.push_back(8'(seed + i));
    m.push_back(8'h80);
    while ((m.size() % 64) != 56) m.push_back(8'h00);
    len = 64'(n) * 64'd8;
    for (int k = 7; k >= 0; k--) m.push_back(len[8*k +: 8]);
    nblk = m.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = m[b*64+j];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_lit(input logic [511:0] d);
    exp_t e;
    e.data  = d;
    e.first = 1'b1;
    e.last  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input int n, input logic [7:0] seed, input bit stop_with_last);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (mon_valid && block_ready && t < 200) begin
        tick();
        t++;
      end
      if (t >= 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got block_valid stuck expected release");
      end
      byte_rdy  = 1'b1;
      data_in   = 8'(seed + i);
      byte_stop = stop_with_last && (i == n - 1);
      tick();
      byte_rdy  = 1'b0;
    end
    byte_stop = 1'b1;
  endtask

  task automatic finish_msg();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    checks++;
    if (t >= 400) begin
      errors++;
      $display("FAIL blocks_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
    byte_stop = 1'b0;
    tick();
    tick();
    check("busy_idle", 512'(mon_busy), 512'(0));
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    byte_rdy = 1'b0; byte_stop = 1'b0; data_in = 8'h00; block_ready = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0;
    tick();

    check("rst_valid", 512'(bv_a), 512'(0));
    check("rst_data", bd_a, 512'(0));
    check("rst_first", 512'(bf_a), 512'(0));
    check("rst_last", 512'(bl_a), 512'(0));
    check("rst_busy", 512'(busy_a), 512'(0));
    check("rst_errs", 512'({ovf_a, drp_a}), 512'(0));

    push_lit({32'h61626380, 416'h0, 64'h18});
    send_msg(3, 8'h61, 1'b0);
    finish_msg();

    push_lit({8'h80, 440'h0, 64'h0});
    send_msg(0, 8'h00, 1'b0);
    finish_msg();

    push_msg(55, 8'h10);
    send_msg(55, 8'h10, 1'b1);
    finish_msg();

    push_msg(56, 8'h20);
    send_msg(56, 8'h20, 1'b0);
    finish_msg();

    push_msg(64, 8'hA0);
    send_msg(64, 8'hA0, 1'b1);
    finish_msg();

    push_msg(130, 8'h33);
    send_msg(130, 8'h33, 1'b0);
    finish_msg();

    check("no_drop", 512'(drp_a), 512'(0));
    check("no_overflow", 512'(ovf_a), 512'(0));

    // backpressure: full block held for 10 cycles, stray byte dropped
    block_ready = 1'b0;
    push_msg(64, 8'h5A);
    send_msg(64, 8'h5A, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_valid", 512'(bv_a), 512'(1));
      check("stall_data", bd_a, exp_q[0].data);
    end
    tick();
    byte_rdy = 1'b1;
    data_in  = 8'hFF;
    tick();
    byte_rdy = 1'b0;
    check("drop_err_set", 512'(drp_a), 512'(1));
    check("stall_data_after_drop", bd_a, exp_q[0].data);
    block_ready = 1'b1;
    finish_msg();
    check("drop_err_sticky", 512'(drp_a), 512'(1));

    // reset while a final block waits for acceptance
    block_ready = 1'b0;
    send_msg(3, 8'h01, 1'b0);
    for (int t = 0; t < 20 && !bv_a; t++) tick();
    check("pre_reset_valid", 512'(bv_a), 512'(1));
    rst_a = 1'b1;
    #1;
    check("async_valid", 512'(bv_a), 512'(0));
    check("async_data", bd_a, 512'(0));
    check("async_drop", 512'(drp_a), 512'(0));
    check("async_busy", 512'(busy_a), 512'(0));
    byte_stop   = 1'b0;
    block_ready = 1'b1;
    exp_q.delete();
    tick();

    // narrow counter: 16th byte overflows, length saturates at 15 bytes
    sel_b = 1'b1;
    tick();
    rst_b = 1'b0;
    tick();
    check("b_rst_ovf", 512'(ovf_b), 512'(0));
    push_lit({8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
              8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D, 8'h4E, 8'h80,
              320'h0, 64'h78});
    send_msg(16, 8'h40, 1'b0);
    finish_msg();
    check("b_overflow", 512'(mon_ovf), 512'(1));
    check("b_no_drop", 512'(mon_drop), 512'(0));
    rst_b = 1'b1;
    #1;
    check("b_reset_clears", 512'(ovf_b), 512'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
